// File: rtl/cmd_dispatch.sv
// Opcode dispatcher: gives one handler the shared UART TX port for the length of its command, and answers unknown opcodes with a NAK.
// Optional build macro CMD_DISPATCH_TIMEOUT_EN adds an idle-timeout abort in RUN that sends 8'hEF.
module cmd_dispatch #(
    parameter int          N_HANDLERS     = 4,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic [N_HANDLERS-1:0]   activate,
    input  logic [N_HANDLERS-1:0]   done,
    input  logic [8*N_HANDLERS-1:0] h_tx_data,
    input  logic [N_HANDLERS-1:0]   h_tx_start,
    output logic                    busy,
    output logic                    err_pulse
);

    localparam int OPW = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_RUN,
        S_RELEASE,
        S_NAK_WAIT,
        S_NAK_SEND,
        S_NAK_HOLD
`ifdef CMD_DISPATCH_TIMEOUT_EN
        , S_TO_WAIT
        , S_TO_SEND
`endif
    } state_t;

    state_t                  state_q;
    logic [OPW-1:0]          opcode_q;
    logic                    rx_ready_q;
    logic [N_HANDLERS-1:0]   activate_q;
    logic                    tx_start_q;
    logic [7:0]              tx_data_q;
    logic                    err_pulse_q;

    logic       rx_rise;
    logic       sel_done;
    logic       sel_start;
    logic [7:0] sel_data;

    assign rx_rise   = rx_ready & ~rx_ready_q;
    assign sel_done  = done[opcode_q];
    assign sel_start = h_tx_start[opcode_q];
    assign sel_data  = h_tx_data[{opcode_q, 3'b000} +: 8];

`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic [23:0] count_q;
    logic        rx_change;
    assign rx_change = rx_ready ^ rx_ready_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            rx_ready_q  <= 1'b0;
            activate_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            err_pulse_q <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            count_q     <= '0;
`endif
        end else begin
            rx_ready_q  <= rx_ready;
            tx_start_q  <= 1'b0;
            err_pulse_q <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            count_q     <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (rx_rise) begin
                        if ({24'd0, rx_data} < N_HANDLERS) begin
                            opcode_q <= rx_data[OPW-1:0];
                            state_q  <= S_ACT;
                        end else begin
                            state_q  <= S_NAK_WAIT;
                        end
                    end
                end
                S_ACT: begin
                    activate_q <= N_HANDLERS'(1) << opcode_q;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    // Pass-through is registered; other handlers' strobes never reach the port.
                    tx_data_q <= sel_data;
                    if (sel_done) begin
                        activate_q <= '0;
                        state_q    <= S_RELEASE;
                    end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                    else if (count_q == TIMEOUT_CYCLES) begin
                        activate_q <= '0;
                        state_q    <= S_TO_WAIT;
                    end
`endif
                    else begin
                        tx_start_q <= sel_start;
                    end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                    if (!sel_done)
                        count_q <= (tx_active || rx_change) ? 24'd0 : count_q + 24'd1;
`endif
                end
                S_RELEASE: begin
                    if (!sel_done)
                        state_q <= S_IDLE;
                end
                S_NAK_WAIT: begin
                    if (!tx_active) begin
                        tx_data_q   <= NAK_BYTE;
                        tx_start_q  <= 1'b1;
                        err_pulse_q <= 1'b1;
                        state_q     <= S_NAK_SEND;
                    end
                end
                S_NAK_SEND: state_q <= S_NAK_HOLD;
                S_NAK_HOLD: begin
                    if (tx_done)
                        state_q <= S_IDLE;
                end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                S_TO_WAIT: begin
                    if (!tx_active) begin
                        tx_data_q   <= 8'hEF;
                        tx_start_q  <= 1'b1;
                        err_pulse_q <= 1'b1;
                        state_q     <= S_TO_SEND;
                    end
                end
                S_TO_SEND: state_q <= S_RELEASE;
`endif
                default: begin
                    activate_q <= '0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign activate  = activate_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign err_pulse = err_pulse_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch: reset, dispatch, NAK, handler isolation, mid-command reset, optional timeout.
module tb_cmd_dispatch;

    logic        clk;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_active;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [3:0]  activate;
    logic [3:0]  done;
    logic [31:0] h_tx_data;
    logic [3:0]  h_tx_start;
    logic        busy;
    logic        err_pulse;

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;

    cmd_dispatch #(
        .N_HANDLERS    (4),
        .NAK_BYTE      (8'hEE),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .activate  (activate),
        .done      (done),
        .h_tx_data (h_tx_data),
        .h_tx_start(h_tx_start),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (tx_start === 1'b1) n_pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
        done = '0; h_tx_data = '0; h_tx_start = '0;
        step(); step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL rst_activate: got %b expected 0000", activate); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_pulse); end
        reset = 1'b0;
        h_tx_data[7:0] = 8'h5A;
        rx_data = 8'h00; rx_ready = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b0001) begin errors++; $display("FAIL rst_pre_activate: got %b expected 0001", activate); end
        step();
        rx_ready = 1'b0;
        reset = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL rst2_activate: got %b expected 0000", activate); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst2_tx_data: got %h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst2_busy: got %b expected 0", busy); end
        reset = 1'b0;
        h_tx_data = '0;
        step();
    endtask

    task automatic test_handler1();
        int p0;
        p0 = n_pulses;
        rx_data = 8'h01; rx_ready = 1'b1;
        step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL h1_act_early: got %b expected 0000", activate); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL h1_busy: got %b expected 1", busy); end
        step();
        checks++; if (activate !== 4'b0010) begin errors++; $display("FAIL h1_activate: got %b expected 0010", activate); end
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h_tx_data[15:8] = 8'(i);
            h_tx_start[1] = 1'b1;
            step();
            checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL h1_start%0d: got %b expected 1", i, tx_start); end
            checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL h1_data%0d: got %h expected %h", i, tx_data, 8'(i)); end
            h_tx_start[1] = 1'b0;
            step();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL h1_gap%0d: got %b expected 0", i, tx_start); end
        end
        done[1] = 1'b1;
        step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL h1_drop: got %b expected 0000", activate); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL h1_release: got %b expected 1", busy); end
        done[1] = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL h1_idle: got %b expected 0", busy); end
        checks++; if (n_pulses - p0 !== 3) begin errors++; $display("FAIL h1_pulses: got %0d expected 3", n_pulses - p0); end
    endtask

    task automatic test_nak();
        logic [7:0] codes [2];
        int p0;
        codes[0] = 8'h07;
        codes[1] = 8'h04;
        for (int k = 0; k < 2; k++) begin
            p0 = n_pulses;
            tx_active = 1'b1;
            rx_data = codes[k]; rx_ready = 1'b1;
            step();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nak_busy%0d: got %b expected 1", k, busy); end
            step();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL nak_wait%0d: got %b expected 0", k, tx_start); end
            tx_active = 1'b0;
            step();
            checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL nak_start%0d: got %b expected 1", k, tx_start); end
            checks++; if (tx_data !== 8'hEE) begin errors++; $display("FAIL nak_data%0d: got %h expected ee", k, tx_data); end
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL nak_err%0d: got %b expected 1", k, err_pulse); end
            checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL nak_act%0d: got %b expected 0000", k, activate); end
            step();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL nak_start_end%0d: got %b expected 0", k, tx_start); end
            checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL nak_err_end%0d: got %b expected 0", k, err_pulse); end
            rx_ready = 1'b0;
            step();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nak_hold%0d: got %b expected 1", k, busy); end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nak_idle%0d: got %b expected 0", k, busy); end
            checks++; if (n_pulses - p0 !== 1) begin errors++; $display("FAIL nak_pulses%0d: got %0d expected 1", k, n_pulses - p0); end
        end
    endtask

    task automatic test_isolation();
        rx_data = 8'h02; rx_ready = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b0100) begin errors++; $display("FAIL iso_activate: got %b expected 0100", activate); end
        rx_ready = 1'b0;
        h_tx_data[7:0] = 8'h11;
        h_tx_data[23:16] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            h_tx_start[0] = ~h_tx_start[0];
            done[0] = ~done[0];
            step();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL iso_foreign%0d: got %b expected 0", i, tx_start); end
            checks++; if (activate !== 4'b0100) begin errors++; $display("FAIL iso_hold%0d: got %b expected 0100", i, activate); end
        end
        h_tx_start = 4'b0101;
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL iso_start: got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL iso_data: got %h expected a5", tx_data); end
        h_tx_start = '0;
        done = 4'b0101;
        step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL iso_drop: got %b expected 0000", activate); end
        done = '0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iso_idle: got %b expected 0", busy); end
        h_tx_data = '0;
    endtask

    task automatic test_reset_mid_run();
        rx_data = 8'h03; rx_ready = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b1000) begin errors++; $display("FAIL mid_activate: got %b expected 1000", activate); end
        rx_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL mid_drop: got %b expected 0000", activate); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", busy); end
        reset = 1'b0;
        rx_data = 8'h00; rx_ready = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b0001) begin errors++; $display("FAIL mid_next: got %b expected 0001", activate); end
        rx_ready = 1'b0;
        done[0] = 1'b1;
        step();
        checks++; if (activate !== 4'b0000) begin errors++; $display("FAIL mid_next_drop: got %b expected 0000", activate); end
        done[0] = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_next_idle: got %b expected 0", busy); end
    endtask

`ifdef CMD_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        int waited;
        rx_data = 8'h01; rx_ready = 1'b1;
        step(); step();
        checks++; if (activate !== 4'b0010) begin errors++; $display("FAIL to_activate: got %b expected 0010", activate); end
        cycles = 0;
        while (activate !== 4'b0000 && cycles < 300) begin
            step();
            cycles++;
        end
        checks++; if (cycles < 100 || cycles > 101) begin errors++; $display("FAIL to_cycles: got %0d expected 100..101", cycles); end
        waited = 0;
        while (tx_start !== 1'b1 && waited < 5) begin
            step();
            waited++;
        end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'hEF) begin errors++; $display("FAIL to_data: got %h expected ef", tx_data); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err_pulse); end
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b expected 0", busy); end
        rx_ready = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_handler1();
        test_nak();
        test_isolation();
        test_reset_mid_run();
`ifdef CMD_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
